// File: rtl/ysyx_22050612_ifu_fetch.sv
// Non-speculative instruction fetch: one 32-bit instruction in flight, PC advanced from execute's dnpc.
// Optional feature macro: IFU_ALIGN_CHECK_EN (misaligned dnpc faults instead of being truncated).
module ysyx_22050612_ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        exu_done,
  input  logic [63:0] exu_dnpc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_NPC,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d = S_FAULT;
          end else begin
            inst_d    = pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready) state_d = S_NPC;
      end
      S_NPC: begin
        if (exu_done) begin
`ifdef IFU_ALIGN_CHECK_EN
          if (exu_dnpc[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = exu_dnpc;
            state_d = S_REQ;
          end
`else
          pc_d    = {exu_dnpc[63:2], 2'b00};
          state_d = S_REQ;
`endif
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

`ifndef IFU_ALIGN_CHECK_EN
  logic unused_dnpc_lsbs;
  assign unused_dnpc_lsbs = ^exu_dnpc[1:0];
`endif

  // Address is gated so every output reads zero while held in reset.
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = imem_req_valid ? {pc_q[63:3], 3'b000} : '0;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_ysyx_22050612_ifu_fetch.sv
// Randomized bench for ysyx_22050612_ifu_fetch: bench acts as memory and execute, a transaction model
// tracks the expected PC and which outputs must be asserted, and a compare process checks every cycle.
module tb_ysyx_22050612_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        exu_done;
  logic [63:0] exu_dnpc;
  logic        fetch_fault;

  ysyx_22050612_ifu_fetch #(.RESET_PC(64'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .exu_done       (exu_done),
    .exu_dnpc       (exu_dnpc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: what the outputs must be after the most recent clock edge
  logic [63:0] m_pc;
  bit          m_req_ok;
  bit          m_inst_ok;
  bit          m_fault;
  bit          cmp_en;
  int          n_checks;
  int          n_fail;
  logic [63:0] last_addr;
  logic [63:0] last_inst_pc;
  logic [31:0] last_inst;

  function automatic logic [63:0] memfn(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0013_0000_0093;
    return {a[34:3] ^ 32'h9E37_79B9, a[63:32] ^ ~a[31:0]};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    logic [63:0] w;
    w = memfn({pc[63:3], 3'b000});
    return pc[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_valid", 64'(imem_req_valid), 64'(m_req_ok));
      if (m_req_ok) chk("req_addr", imem_req_addr, {m_pc[63:3], 3'b000});
      chk("inst_valid", 64'(inst_valid), 64'(m_inst_ok));
      if (m_inst_ok) begin
        chk("inst", 64'(inst), 64'(exp_inst(m_pc)));
        chk("inst_pc", inst_pc, m_pc);
      end
      chk("fetch_fault", 64'(fetch_fault), 64'(m_fault));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_in();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_resp_data  = {$urandom, $urandom};
    inst_ready      = 1'b0;
    exu_done        = 1'b0;
    exu_dnpc        = {$urandom, $urandom};
  endtask

  task automatic spurious(input bit allow_resp, input bit allow_done);
    if (allow_resp && $urandom_range(0, 3) == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_err   = 1'($urandom_range(0, 1));
    end
    if (allow_done && $urandom_range(0, 3) == 0) exu_done = 1'b1;
  endtask

  task automatic model_reset();
    m_pc      = 64'h8000_0000;
    m_req_ok  = 1'b0;
    m_inst_ok = 1'b0;
    m_fault   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_inst"}, 64'(inst), 64'd0);
    chk({tag, "_inst_pc"}, inst_pc, 64'd0);
    chk({tag, "_fetch_fault"}, 64'(fetch_fault), 64'd0);
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    chk_all_zero("reset");
    rst_n    = 1'b1;
    m_req_ok = 1'b1;
    chk("boot_req_valid", 64'(imem_req_valid), 64'd0);
    tick();
    chk("first_req_addr", imem_req_addr, 64'h8000_0000);
  endtask

  // One full fetch: REQ -> WAIT -> HOLD -> (NPC). Entered while the model expects a request.
  task automatic fetch_one(input bit err, input logic [63:0] dnpc, input int req_dly,
                           input int inst_dly, input bit do_npc);
    int n;
    n = (req_dly < 0) ? int'($urandom_range(0, 3)) : req_dly;
    repeat (n) begin
      clear_in();
      spurious(1'b1, 1'b1);
      tick();
    end
    clear_in();
    spurious(1'b1, 1'b1);
    imem_req_ready = 1'b1;
    last_addr      = imem_req_addr;
    m_req_ok       = 1'b0;
    tick();
    n = int'($urandom_range(0, 3));
    repeat (n) begin
      clear_in();
      spurious(1'b0, 1'b1);
      tick();
    end
    clear_in();
    imem_resp_valid = 1'b1;
    imem_resp_data  = memfn(last_addr);
    imem_resp_err   = err;
    if (err) m_fault = 1'b1;
    else m_inst_ok = 1'b1;
    tick();
    clear_in();
    if (err) return;
    last_inst    = inst;
    last_inst_pc = inst_pc;
    n = (inst_dly < 0) ? int'($urandom_range(0, 3)) : inst_dly;
    repeat (n) begin
      clear_in();
      spurious(1'b1, 1'b1);
      tick();
    end
    clear_in();
    spurious(1'b1, 1'b1);
    inst_ready = 1'b1;
    m_inst_ok  = 1'b0;
    tick();
    clear_in();
    if (!do_npc) return;
    n = int'($urandom_range(0, 2));
    repeat (n) begin
      clear_in();
      spurious(1'b1, 1'b0);
      tick();
    end
    clear_in();
    exu_done = 1'b1;
    exu_dnpc = dnpc;
`ifdef IFU_ALIGN_CHECK_EN
    if (dnpc[1:0] != 2'b00) begin
      m_fault = 1'b1;
    end else begin
      m_pc     = dnpc;
      m_req_ok = 1'b1;
    end
`else
    m_pc     = dnpc & ~64'h3;
    m_req_ok = 1'b1;
`endif
    tick();
    clear_in();
  endtask

  task automatic idle_faulted(input int cycles);
    repeat (cycles) begin
      clear_in();
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      spurious(1'b1, 1'b1);
      tick();
    end
    clear_in();
  endtask

  // Reset asserted between clock edges while a response is outstanding; late response then ignored.
  task automatic reset_in_wait();
    clear_in();
    imem_req_ready = 1'b1;
    last_addr      = imem_req_addr;
    m_req_ok       = 1'b0;
    tick();
    clear_in();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = memfn(last_addr);
    rst_n           = 1'b1;
    m_req_ok        = 1'b1;
    tick();
    clear_in();
    imem_resp_valid = 1'b1;
    imem_resp_data  = memfn(last_addr);
    tick();
    clear_in();
  endtask

  initial begin
    logic [63:0] dn;
    int unsigned r;
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b1;
    clear_in();
    model_reset();
    #2;
    rst_n  = 1'b0;
    cmp_en = 1'b1;
    tick();
    do_reset();

    fetch_one(1'b0, 64'h8000_0004, 0, 0, 1'b1);
    chk("t1_addr", last_addr, 64'h8000_0000);
    chk("t1_inst", 64'(last_inst), 64'h0000_0093);
    chk("t1_inst_pc", last_inst_pc, 64'h8000_0000);

    fetch_one(1'b0, 64'h8000_0102, 5, 3, 1'b1);
    chk("t2_addr", last_addr, 64'h8000_0000);
    chk("t2_inst", 64'(last_inst), 64'h0000_0013);
    chk("t2_inst_pc", last_inst_pc, 64'h8000_0004);

`ifdef IFU_ALIGN_CHECK_EN
    chk("t5_fault", 64'(fetch_fault), 64'd1);
    idle_faulted(4);
    do_reset();
`else
    fetch_one(1'b0, 64'h8000_0000, -1, -1, 1'b1);
    chk("t5_addr", last_addr, 64'h8000_0100);
    chk("t5_inst_pc", last_inst_pc, 64'h8000_0100);
`endif

    fetch_one(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, -1, -1, 1'b1);
    fetch_one(1'b0, 64'h0000_0000_0000_0008, -1, -1, 1'b1);
    chk("top_addr", last_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("top_inst_pc", last_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    fetch_one(1'b1, 64'h0, -1, -1, 1'b1);
    chk("t4_fault", 64'(fetch_fault), 64'd1);
    idle_faulted(5);
    chk("t4_fault_sticky", 64'(fetch_fault), 64'd1);
    do_reset();

    reset_in_wait();
    fetch_one(1'b0, 64'h8000_0010, -1, -1, 1'b1);
    chk("t6_inst_pc", last_inst_pc, 64'h8000_0000);
    chk("t6_inst", 64'(last_inst), 64'h0000_0093);

    for (int unsigned i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      dn = m_pc + 64'd4;
      else if (r == 6) dn = {$urandom, $urandom} & ~64'h3;
      else if (r == 7) dn = m_pc + 64'($urandom_range(9, 11));
      else if (r == 8) dn = 64'hFFFF_FFFF_FFFF_FFFC;
      else             dn = m_pc - 64'd4;
      fetch_one($urandom_range(0, 24) == 0, dn, -1, -1, 1'b1);
      if (m_fault) begin
        idle_faulted(2);
        do_reset();
      end
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
